// File: rtl/demux_pkg.sv
// Shared types and sizes for the 1-to-8 registered demultiplexer.
package demux_pkg;

    localparam int unsigned N_CH  = 8;
    localparam int unsigned SEL_W = 3;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [N_CH-1:0]  ch_vec_t;

    // Highest channel index; a scan transfer here completes a frame.
    localparam sel_t LAST_CH = sel_t'(N_CH - 1);

endpackage

// File: rtl/demux_scan_ptr.sv
// Scan-mode engine for demux_1to8_seq: round-robin channel pointer, bit
// accumulator, assembled frame with valid/ack handshake, and the input
// back-pressure that stalls only the frame-completing bit.
module demux_scan_ptr
    import demux_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    scan,
    input  logic    din,
    input  logic    din_valid,
    input  logic    frame_ack,
    output sel_t    ptr,
    output logic    din_ready,
    output ch_vec_t frame,
    output logic    frame_valid
);

    // Bit 7 never needs storing: it goes straight into the frame.
    logic [N_CH-2:0] acc_q, acc_d;
    sel_t            ptr_q, ptr_d;
    ch_vec_t         frame_q, frame_d;
    logic            frame_valid_q, frame_valid_d;
    logic            at_last;
    logic            xfer;

    assign at_last = (ptr_q == LAST_CH);
    assign xfer    = din_valid && din_ready;

    // State register: pointer, accumulator and frame holding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q         <= '0;
            acc_q         <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            acc_q         <= acc_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    // Next state: advance on transfers in scan mode, park at zero otherwise.
    always_comb begin
        ptr_d         = ptr_q;
        acc_d         = acc_q;
        frame_d       = frame_q;
        frame_valid_d = frame_valid_q;
        if (frame_valid_q && frame_ack) begin
            frame_valid_d = 1'b0;
        end
        if (!scan) begin
            ptr_d = '0;
            acc_d = '0;
        end else if (xfer) begin
            if (at_last) begin
                // A new frame wins over a same-cycle ack.
                frame_d       = {din, acc_q};
                frame_valid_d = 1'b1;
                ptr_d         = '0;
            end else begin
                ptr_d = ptr_q + 1'b1;
                for (int unsigned i = 0; i < N_CH - 1; i++) begin
                    if (ptr_q == sel_t'(i)) begin
                        acc_d[i] = din;
                    end
                end
            end
        end
    end

    // Outputs: stall only the completing bit while the old frame is unconsumed.
    always_comb begin
        din_ready   = !(scan && at_last && frame_valid_q && !frame_ack);
        ptr         = ptr_q;
        frame       = frame_q;
        frame_valid = frame_valid_q;
    end

endmodule

// File: rtl/demux_1to8_seq.sv
// Registered 1-to-8 demultiplexer. Direct mode steers din to y[s].
// Optional scan mode (macro DEMUX_SCAN_EN) walks the channels round-robin
// and assembles 8-bit frames behind a valid/ack handshake.
module demux_1to8_seq
    import demux_pkg::*;
#(
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    din,
    input  logic    din_valid,
    output logic    din_ready,
    input  sel_t    s,
`ifdef DEMUX_SCAN_EN
    input  logic    scan,
    output ch_vec_t frame,
    output logic    frame_valid,
    input  logic    frame_ack,
`endif
    output ch_vec_t y,
    output logic    y_valid
);

    sel_t    ch;
    logic    xfer;
    ch_vec_t y_q, y_d;
    logic    y_valid_q;

`ifdef DEMUX_SCAN_EN
    sel_t ptr;

    demux_scan_ptr u_scan_ptr (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan        (scan),
        .din         (din),
        .din_valid   (din_valid),
        .frame_ack   (frame_ack),
        .ptr         (ptr),
        .din_ready   (din_ready),
        .frame       (frame),
        .frame_valid (frame_valid)
    );

    assign ch = scan ? ptr : s;
`else
    assign din_ready = 1'b1;
    assign ch        = s;
`endif

    assign xfer = din_valid && din_ready;

    // Channel outputs: selected bit takes din, all others idle.
    always_comb begin
        y_d = y_q;
        if (xfer) begin
            y_d     = {N_CH{IDLE_VAL}};
            y_d[ch] = din;
        end
    end

    // Output registers; y_valid marks the cycle after each transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= {N_CH{IDLE_VAL}};
            y_valid_q <= 1'b0;
        end else begin
            y_q       <= y_d;
            y_valid_q <= xfer;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_demux_1to8_seq.sv
// Self-checking bench for demux_1to8_seq. Two instances (IDLE_VAL 0 and 1)
// share stimulus; a behavioural model tracks outputs, scan position and
// frames. Scan checks are built only with DEMUX_SCAN_EN.
module tb_demux_1to8_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din, din_valid, scan, frame_ack;
    logic [2:0] s;
    logic [7:0] y0, y1, frame0, frame1;
    logic       yv0, yv1, rdy0, rdy1, fv0, fv1;

    always #5 clk = ~clk;

    demux_1to8_seq #(.IDLE_VAL(1'b0)) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (rdy0),
        .s           (s),
`ifdef DEMUX_SCAN_EN
        .scan        (scan),
        .frame       (frame0),
        .frame_valid (fv0),
        .frame_ack   (frame_ack),
`endif
        .y           (y0),
        .y_valid     (yv0)
    );

    demux_1to8_seq #(.IDLE_VAL(1'b1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (rdy1),
        .s           (s),
`ifdef DEMUX_SCAN_EN
        .scan        (scan),
        .frame       (frame1),
        .frame_valid (fv1),
        .frame_ack   (frame_ack),
`endif
        .y           (y1),
        .y_valid     (yv1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model
    logic [7:0] m_y0, m_y1, m_bits, m_frame;
    logic       m_yv, m_fv;
    int         m_cnt;

    task automatic model_reset();
        m_y0 = 8'h00; m_y1 = 8'hFF; m_yv = 1'b0;
        m_bits = 8'h00; m_frame = 8'h00; m_fv = 1'b0; m_cnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".y0"}, y0, m_y0);
        check({tag, ".y1"}, y1, m_y1);
        check({tag, ".yv0"}, {7'd0, yv0}, {7'd0, m_yv});
        check({tag, ".yv1"}, {7'd0, yv1}, {7'd0, m_yv});
`ifdef DEMUX_SCAN_EN
        check({tag, ".frame0"}, frame0, m_frame);
        check({tag, ".frame1"}, frame1, m_frame);
        check({tag, ".fv0"}, {7'd0, fv0}, {7'd0, m_fv});
        check({tag, ".fv1"}, {7'd0, fv1}, {7'd0, m_fv});
`endif
    endtask

    // One clock of stimulus with model update and checks.
    task automatic step(input logic d, input logic v, input logic [2:0] sel,
                        input logic sc, input logic ack);
        logic eff_scan, rdy, xfer;
        int   ch;
        @(negedge clk);
        din = d; din_valid = v; s = sel; scan = sc; frame_ack = ack;
`ifdef DEMUX_SCAN_EN
        eff_scan = sc;
`else
        eff_scan = 1'b0;
`endif
        #1;
        rdy = !(eff_scan && m_cnt == 7 && m_fv && !ack);
        check("din_ready0", {7'd0, rdy0}, {7'd0, rdy});
        check("din_ready1", {7'd0, rdy1}, {7'd0, rdy});
        xfer = v && rdy;
        ch   = eff_scan ? m_cnt : int'(sel);
        @(posedge clk);
        #1;
        if (xfer) begin
            for (int k = 0; k < 8; k++) begin
                m_y0[k] = (k == ch) ? d : 1'b0;
                m_y1[k] = (k == ch) ? d : 1'b1;
            end
        end
        m_yv = xfer;
        if (m_fv && ack) m_fv = 1'b0;
        if (!eff_scan) begin
            m_cnt  = 0;
            m_bits = 8'h00;
        end else if (xfer) begin
            m_bits[m_cnt] = d;
            if (m_cnt == 7) begin
                m_frame = m_bits;
                m_fv    = 1'b1;
                m_cnt   = 0;
            end else begin
                m_cnt++;
            end
        end
        check_outputs("step");
    endtask

    logic [7:0] pat;
    logic       cur_scan;

    initial begin
        rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; s = 3'd0; scan = 1'b0; frame_ack = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check_outputs("reset");
        check("reset.rdy", {7'd0, rdy0}, 8'd1);
        rst_n = 1'b1;

        // Direct sweep: one-hot walk on the IDLE_VAL=0 instance.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 3'(i), 1'b0, 1'b0);
            check("sweep.onehot", y0, 8'h01 << i);
        end
        step(1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
        check("idle1.F7", y1, 8'hF7);
        step(1'b1, 1'b0, 3'd5, 1'b0, 1'b0);
        check("hold.F7", y1, 8'hF7);
        check("hold.yv", {7'd0, yv1}, 8'd0);

        // Scan frame 1,0,1,1,0,0,1,0 -> 8'h4D.
        pat = 8'h4D;
        for (int i = 0; i < 8; i++) step(pat[i], 1'b1, 3'd0, 1'b1, 1'b0);
`ifdef DEMUX_SCAN_EN
        check("scan.frame4D", frame0, 8'h4D);
        check("scan.fv", {7'd0, fv0}, 8'd1);
`endif

        // Back-pressure: bits 0..6 accepted, completing bit stalls until ack.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);

        // Mode abort: partial frame discarded on scan drop.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 3'd2, 1'b0, 1'b0);
        pat = 8'hA6;
        for (int i = 0; i < 8; i++) step(pat[i], 1'b1, 3'd0, 1'b1, 1'b0);
`ifdef DEMUX_SCAN_EN
        check("abort.frameA6", frame0, 8'hA6);
`endif
        step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);

        // Randomised traffic.
        cur_scan = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(15) == 0) cur_scan = ~cur_scan;
            step(1'($urandom), ($urandom_range(3) != 0), 3'($urandom), cur_scan,
                 ($urandom_range(3) == 0));
        end

        // Reset mid-frame, asserted between edges.
        step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("midreset");
        check("midreset.rdy", {7'd0, rdy0}, 8'd1);
        @(negedge clk);
        rst_n = 1'b1;
        pat = 8'h3C;
        for (int i = 0; i < 8; i++) step(pat[i], 1'b1, 3'd0, 1'b1, 1'b0);
`ifdef DEMUX_SCAN_EN
        check("postreset.frame3C", frame0, 8'h3C);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
